// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'h0, ADDC = 4'h1, SUB = 4'h2, SUBC = 4'h3,
    CMP  = 4'h4, AND  = 4'h5, OR  = 4'h6, EXOR = 4'h7,
    TEST = 4'h8, LSL  = 4'h9, LSR = 4'hA, ROL  = 4'hB,
    ROR  = 4'hC, ASR  = 4'hD, MOV = 4'hE, MUL  = 4'hF
  } alu_op_t;

  // State literals are prefixed so they do not collide with the MUL opcode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_writes_result(input alu_op_t op);
    return (op != CMP) && (op != TEST);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
module alu_mul_iter import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_nxt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     acc_s;

  // Upper half accumulates the multiplicand when the multiplier LSB is set, then shifts right.
  assign addend_s = prod_r[0] ? mcand_r : {WIDTH{1'b0}};
  assign acc_s    = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
  assign prod_nxt = {acc_s, prod_r[WIDTH-1:1]};
  assign busy     = busy_r;
  assign last     = busy_r && (cnt_r == LAST_CNT);

  // Product, multiplicand and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r  <= '0;
      mcand_r <= '0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else if (load) begin
      prod_r  <= {{WIDTH{1'b0}}, b};
      mcand_r <= a;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
    end else if (abort) begin
      busy_r  <= 1'b0;
    end else if (step && busy_r) begin
      prod_r  <= prod_nxt;
      cnt_r   <= cnt_r + CW'(1);
      busy_r  <= !last;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/ready/done handshake, C/Z flag register and iterative MUL.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             flg_ld,
  input  logic             c_in,
  input  logic             z_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             wr_en,
  output logic             c,
  output logic             z
);

  state_t             state_r, state_nxt_s;
  alu_op_t            op_s;
  logic               ready_r, done_r, wr_en_r, c_r, z_r;
  logic [WIDTH-1:0]   result_r, result_hi_r, res_s;
  logic               accept_s, cin_s, cout_s, flg_upd_s;
  logic               fin_alu_s, fin_mul_s, mul_load_s, mul_step_s;
  logic               mul_busy_s, mul_last_s;
  logic [WIDTH:0]     sum_s, diff_s;
  logic [2*WIDTH-1:0] prod_nxt_s;

  assign op_s     = alu_op_t'(sel);
  assign accept_s = start && ready_r && !flg_ld && (state_r == ST_IDLE);
  assign cin_s    = ((op_s == ADDC) || (op_s == SUBC)) ? c_r : 1'b0;
  assign sum_s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
  assign diff_s   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_s};

  assign fin_alu_s  = accept_s && (op_s != MUL);
  assign mul_load_s = accept_s && (op_s == MUL);
  assign mul_step_s = (state_r == ST_MUL) && !flush;
  assign fin_mul_s  = mul_step_s && mul_last_s;

  // Single-cycle operation decode; flg_upd_s=0 leaves the flag register alone.
  always_comb begin
    res_s     = '0;
    cout_s    = c_r;
    flg_upd_s = 1'b1;
    case (op_s)
      ADD, ADDC:       begin res_s = sum_s[WIDTH-1:0];  cout_s = sum_s[WIDTH];  end
      SUB, SUBC, CMP:  begin res_s = diff_s[WIDTH-1:0]; cout_s = diff_s[WIDTH]; end
      AND, TEST:       begin res_s = a & b; cout_s = 1'b0; end
      OR:              begin res_s = a | b; cout_s = 1'b0; end
      EXOR:            begin res_s = a ^ b; cout_s = 1'b0; end
      LSL:             begin res_s = {a[WIDTH-2:0], c_r};      cout_s = a[WIDTH-1]; end
      LSR:             begin res_s = {c_r, a[WIDTH-1:1]};      cout_s = a[0]; end
      ROL:             begin res_s = {a[WIDTH-2:0], a[WIDTH-1]}; cout_s = a[WIDTH-1]; end
      ROR:             begin res_s = {a[0], a[WIDTH-1:1]};     cout_s = a[0]; end
      ASR:             begin res_s = {a[WIDTH-1], a[WIDTH-1:1]}; cout_s = a[0]; end
      MOV:             begin res_s = b; flg_upd_s = 1'b0; end
      default:         begin res_s = '0; flg_upd_s = 1'b0; end
    endcase
  end

  // Next-state logic; flush returns to IDLE from any busy state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = (op_s == MUL) ? ST_MUL : ST_DONE;
        else          state_nxt_s = ST_IDLE;
      end
      ST_MUL: begin
        if (flush)           state_nxt_s = ST_IDLE;
        else if (mul_last_s) state_nxt_s = ST_DONE;
        else                 state_nxt_s = ST_MUL;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mul_load_s),
    .step     (mul_step_s),
    .abort    (flush),
    .a        (a),
    .b        (b),
    .busy     (mul_busy_s),
    .last     (mul_last_s),
    .prod_nxt (prod_nxt_s)
  );

  // State, handshake, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      wr_en_r     <= 1'b0;
      result_r    <= '0;
      result_hi_r <= '0;
      c_r         <= 1'b0;
      z_r         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      done_r  <= fin_alu_s || fin_mul_s;
      if (fin_alu_s) begin
        result_r    <= res_s;
        result_hi_r <= '0;
        wr_en_r     <= op_writes_result(op_s);
      end else if (fin_mul_s) begin
        result_r    <= prod_nxt_s[WIDTH-1:0];
        result_hi_r <= prod_nxt_s[2*WIDTH-1:WIDTH];
        wr_en_r     <= 1'b1;
      end else begin
        wr_en_r     <= 1'b0;
      end
      // An explicit flag load outranks any completing op on the same edge.
      if (flg_ld) begin
        c_r <= c_in;
        z_r <= z_in;
      end else if (fin_alu_s && flg_upd_s) begin
        c_r <= cout_s;
        z_r <= (res_s == '0);
      end else if (fin_mul_s) begin
        c_r <= |prod_nxt_s[2*WIDTH-1:WIDTH];
        z_r <= (prod_nxt_s == '0);
      end
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign wr_en     = wr_en_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign c         = c_r;
  assign z         = z_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk, rst_n, start, flush, flg_ld, c_in, z_in;
  logic [3:0] sel;
  logic [7:0] a, b;
  logic       ready, done, wr_en, c, z;
  logic [7:0] result, result_hi;
  int         errors, checks;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a(a), .b(b),
    .flush(flush), .flg_ld(flg_ld), .c_in(c_in), .z_in(z_in),
    .ready(ready), .done(done), .result(result), .result_hi(result_hi),
    .wr_en(wr_en), .c(c), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op and wait (bounded) for done; lat=0 means done never came.
  task automatic run_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv, output int lat);
    start = 1'b1; sel = op; a = av; b = bv;
    tick();
    start = 1'b0; sel = 4'h6; a = 8'hA5; b = 8'h5A;
    lat = 1;
    while (!done && lat < 20) begin tick(); lat++; end
    if (!done) lat = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; flg_ld = 1'b0; c_in = 1'b0; z_in = 1'b0;
    sel = 4'h0; a = 8'h00; b = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0h exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", done); end
    checks++; if ({c, z} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {c, z}); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (result_hi !== 8'h00) begin errors++; $display("FAIL reset_result_hi got=%h exp=00", result_hi); end
  endtask

  task automatic test_add();
    int lat;
    run_op(4'h0, 8'hFF, 8'h01, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL add_result got=%h exp=00", result); end
    checks++; if ({c, z} !== 2'b11) begin errors++; $display("FAIL add_flags got=%b exp=11", {c, z}); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL add_wr_en got=%0h exp=1", wr_en); end
    tick();
    checks++; if ({ready, done} !== 2'b10) begin errors++; $display("FAIL add_idle got=%b exp=10", {ready, done}); end
    run_op(4'h1, 8'h10, 8'h20, lat);
    checks++; if (result !== 8'h31) begin errors++; $display("FAIL addc_result got=%h exp=31", result); end
    checks++; if ({c, z} !== 2'b00) begin errors++; $display("FAIL addc_flags got=%b exp=00", {c, z}); end
    tick();
  endtask

  task automatic test_sub_cmp_mov();
    int lat;
    run_op(4'h2, 8'h05, 8'h07, lat);
    checks++; if (result !== 8'hFE) begin errors++; $display("FAIL sub_result got=%h exp=fe", result); end
    checks++; if ({c, z} !== 2'b10) begin errors++; $display("FAIL sub_flags got=%b exp=10", {c, z}); end
    tick();
    run_op(4'h4, 8'h33, 8'h33, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL cmp_latency got=%0d exp=1", lat); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL cmp_wr_en got=%0h exp=0", wr_en); end
    checks++; if ({c, z} !== 2'b01) begin errors++; $display("FAIL cmp_flags got=%b exp=01", {c, z}); end
    tick();
    run_op(4'hE, 8'h77, 8'h00, lat);
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL mov_result got=%h exp=00", result); end
    checks++; if ({c, z} !== 2'b01) begin errors++; $display("FAIL mov_flags got=%b exp=01", {c, z}); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL mov_wr_en got=%0h exp=1", wr_en); end
    tick();
  endtask

  task automatic test_mul();
    int cyc;
    int early;
    early = 0;
    start = 1'b1; sel = 4'hF; a = 8'h10; b = 8'h10;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00;
    cyc = 1;
    while (!done && cyc < 20) begin
      if (cyc == 3) begin start = 1'b1; sel = 4'h0; a = 8'h01; b = 8'h01; end
      tick();
      start = 1'b0;
      cyc++;
    end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL mul_latency got=%0d exp=9", cyc); end
    checks++; if ({result_hi, result} !== 16'h0100) begin errors++; $display("FAIL mul_product got=%h exp=0100", {result_hi, result}); end
    checks++; if ({c, z} !== 2'b10) begin errors++; $display("FAIL mul_flags got=%b exp=10", {c, z}); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL mul_wr_en got=%0h exp=1", wr_en); end
    tick();
    if (done) early++;
    tick();
    if (done) early++;
    checks++; if (early !== 0) begin errors++; $display("FAIL mul_ignored_start got=%0d exp=0 extra done", early); end
  endtask

  task automatic test_mul_flush();
    int lat;
    int seen;
    seen = 0;
    start = 1'b1; sel = 4'hF; a = 8'hFF; b = 8'hFF;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (done) seen++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (done) seen++;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0h exp=1", ready); end
    checks++; if ({c, z} !== 2'b10) begin errors++; $display("FAIL flush_flags got=%b exp=10", {c, z}); end
    checks++; if ({result_hi, result} !== 16'h0100) begin errors++; $display("FAIL flush_result got=%h exp=0100", {result_hi, result}); end
    for (int i = 0; i < 8; i++) begin tick(); if (done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
    run_op(4'h0, 8'h01, 8'h02, lat);
    checks++; if ({result_hi, result} !== 16'h0003) begin errors++; $display("FAIL flush_add got=%h exp=0003", {result_hi, result}); end
    checks++; if ({c, z} !== 2'b00) begin errors++; $display("FAIL flush_add_flags got=%b exp=00", {c, z}); end
    tick();
  endtask

  task automatic test_flg_ld();
    int lat;
    flg_ld = 1'b1; c_in = 1'b1; z_in = 1'b0;
    start = 1'b1; sel = 4'h0; a = 8'h01; b = 8'h01;
    tick();
    flg_ld = 1'b0; start = 1'b0; c_in = 1'b0;
    checks++; if ({c, z} !== 2'b10) begin errors++; $display("FAIL flgld_flags got=%b exp=10", {c, z}); end
    checks++; if ({ready, done} !== 2'b10) begin errors++; $display("FAIL flgld_blocks_start got=%b exp=10", {ready, done}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flgld_not_queued got=%0h exp=0", done); end
    run_op(4'hA, 8'h02, 8'h00, lat);
    checks++; if (result !== 8'h81) begin errors++; $display("FAIL lsr_result got=%h exp=81", result); end
    checks++; if ({c, z} !== 2'b00) begin errors++; $display("FAIL lsr_flags got=%b exp=00", {c, z}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(4'h0, 8'h03, 8'h04, lat);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done got=%0h exp=0", ready); end
    start = 1'b1; sel = 4'h0; a = 8'h01; b = 8'h01;
    tick();
    start = 1'b0;
    checks++; if ({ready, done, result} !== {2'b10, 8'h07}) begin errors++; $display("FAIL b2b_ignored got=%h exp=207", {ready, done, result}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_not_queued got=%0h exp=0", done); end
    run_op(4'h0, 8'h80, 8'h80, lat);
    tick();
    run_op(4'hB, 8'h81, 8'h00, lat);
    checks++; if ({result, c, z} !== {8'h03, 2'b10}) begin errors++; $display("FAIL b2b_rol got=%h exp=%h", {result, c, z}, {8'h03, 2'b10}); end
    tick();
  endtask

  task automatic test_async_reset();
    int lat;
    run_op(4'h0, 8'hF0, 8'h20, lat);
    checks++; if ({result, c, z} !== {8'h10, 2'b10}) begin errors++; $display("FAIL pre_reset_add got=%h exp=%h", {result, c, z}, {8'h10, 2'b10}); end
    tick();
    start = 1'b1; sel = 4'hF; a = 8'hFF; b = 8'h02;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ready, done, wr_en, c, z} !== 5'b10000) begin errors++; $display("FAIL async_reset_ctrl got=%b exp=10000", {ready, done, wr_en, c, z}); end
    checks++; if ({result_hi, result} !== 16'h0000) begin errors++; $display("FAIL async_reset_result got=%h exp=0000", {result_hi, result}); end
    tick();
    rst_n = 1'b1;
    tick();
    run_op(4'h0, 8'h01, 8'h02, lat);
    checks++; if ({lat, result} !== {32'd1, 8'h03}) begin errors++; $display("FAIL post_reset_add got lat=%0d res=%h exp lat=1 res=03", lat, result); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_sub_cmp_mov();
    test_mul();
    test_mul_flush();
    test_flg_ld();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
